mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide functional unit in the execute stage, directly downstream of issue; consumes the registered mdu_valid and fu_data operands and transaction index.
- Performs RV32M ops: MUL/MULH/MULHSU/MULHU in fixed short latency; DIV/DIVU/REM/REMU with an iterative radix-2 restoring divider.
- Drives one writeback port (result, idx, valid pulse) and a ready signal that is folded into flu_ready.

Parameters:
- IdxWidth, 3, width of the scoreboard transaction index (ScoreboardDepth = 2**IdxWidth).
- FastDivSpecial, 1, when 1, divide-by-zero and signed overflow complete on the fast path instead of iterating.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  abort the in-flight op, no writeback.
- mdu_valid  in  1  issue presents an op this cycle.
- mdu_ready  out  1  unit idle and able to accept.
- operation  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  in  32  rs1 value.
- operand_b  in  32  rs2 value.
- idx_in  in  IdxWidth  scoreboard index of the op.
- wb_valid  out  1  one-cycle result pulse.
- wb_data  out  32  result.
- wb_idx  out  IdxWidth  scoreboard index of the result.

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE, mdu_ready=1, wb_valid=0, wb_data=0, wb_idx=0. Reset mid-operation discards the op with no writeback.
- Accept on mdu_valid && mdu_ready. Latch operation, operands and idx. mdu_ready drops in the next cycle. mdu_valid while not ready is ignored; issue guarantees it does not happen.
- FSM states: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX, DONE.
- IDLE → MUL on an accepted op 0-3.
- IDLE → DIV_PREP on an accepted op 4-7.
- MUL: form the 33x33 signed product of sign/zero-extended operands:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU / MUL: both unsigned extension.
  - MUL takes product[31:0]; the others take product[63:32].
  - Transition to DONE.
- DIV_PREP:
  - Signed ops take absolute values and record the quotient sign (a^b) and the remainder sign (a).
  - If FastDivSpecial and b==0: result = 0xFFFFFFFF for DIV/DIVU, = operand_a for REM/REMU → DONE.
  - If FastDivSpecial and signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV → 0x80000000, REM → 0 → DONE.
  - Otherwise clear the remainder, load the 5-bit counter with 31 → DIV_ITER.
- DIV_ITER: each cycle shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative. Decrement the counter; at counter==0 go to DIV_FIX (32 iterations total).
- DIV_FIX: apply the sign correction (two's complement negate) → DONE.
- With FastDivSpecial=0, the iterative datapath must naturally give the same special-case results.
- DONE: assert wb_valid for exactly 1 cycle with wb_data and wb_idx → IDLE. mdu_ready=1 in the cycle after DONE.
- Latency from acceptance edge to wb_valid:
  - MUL ops: 2 cycles.
  - Divide special cases: 2 cycles.
  - Normal divide: 35 cycles.
- Back-to-back throughput is one op per (latency+1) cycles.
- mdu_ready is registered: 1 only in IDLE.
- wb_data and wb_idx hold their last value when wb_valid=0.
- flush: in any state, next state IDLE, wb_valid=0 next cycle. A flush coinciding with DONE suppresses the pulse (flush wins). A flush coinciding with acceptance in IDLE drops the op.
- All arithmetic is modulo 2^32 on outputs. Divider counter wrap-around is not permitted: the exit is checked at 0.

Test Plan:
- MUL 0x00010000 × 0x00010000 → wb_data 0x00000000 after 2 cycles; MULHU same operands → 0x00000001; wb_idx echoes idx_in=5.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU → 0xFFFFFFFE.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF, DIVU 100/7 → 14, REMU → 2; each wb_valid exactly 35 cycles after acceptance, mdu_ready low throughout.
- Divide by zero: DIVU 0x12345678/0 → 0xFFFFFFFF, REM 0x12345678/0 → 0x12345678; overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; 2-cycle latency with FastDivSpecial=1, 35 with 0, same values.
- Flush at iteration 10 of a DIV → no wb_valid, mdu_ready=1 the next cycle; a new MUL 3×4 is then accepted → 12 after 2 cycles with its own idx.
- reset_n low during DIV_ITER → next cycle wb_valid=0, mdu_ready=1, wb_data=0; a pulse from the aborted op never appears.

Source files
------------

// File: rtl/mdu_unit_if.sv
// rtl/mdu_unit_if.sv - issue/writeback bundle between the issue stage and the multiply/divide unit
interface mdu_unit_if #(
  parameter int IdxWidth = 3
);
  logic                mdu_valid;
  logic                mdu_ready;
  logic [2:0]          operation;
  logic [31:0]         operand_a;
  logic [31:0]         operand_b;
  logic [IdxWidth-1:0] idx_in;
  logic                wb_valid;
  logic [31:0]         wb_data;
  logic [IdxWidth-1:0] wb_idx;

  modport master (
    output mdu_valid, operation, operand_a, operand_b, idx_in,
    input  mdu_ready, wb_valid, wb_data, wb_idx
  );

  modport slave (
    input  mdu_valid, operation, operand_a, operand_b, idx_in,
    output mdu_ready, wb_valid, wb_data, wb_idx
  );
endinterface

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - RV32M multiply/divide unit: short-latency multiply, radix-2 restoring divider
module mdu_unit #(
  parameter int IdxWidth       = 3,
  parameter bit FastDivSpecial = 1'b1
) (
  input logic       clock,
  input logic       reset_n,
  input logic       flush,
  mdu_unit_if.slave bus
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX,
    DONE
  } state_e;

  state_e              state_q;
  logic [2:0]          op_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic [IdxWidth-1:0] idx_q;
  logic [31:0]         rem_q;
  logic [31:0]         quo_q;
  logic [31:0]         div_q;
  logic [4:0]          cnt_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [31:0]         res_q;
  logic                ready_q;
  logic                wb_valid_q;
  logic [31:0]         wb_data_q;
  logic [IdxWidth-1:0] wb_idx_q;

  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic signed [63:0] prod;
  logic               div_signed;
  logic               is_rem;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic               sgn_ovf;
  logic [31:0]        a_abs;
  logic [31:0]        b_abs;
  logic [32:0]        shifted;
  logic               trial_ok;
  logic [31:0]        rem_next;
  logic [31:0]        quo_fixed;
  logic [31:0]        rem_fixed;

  // Sign-extending to 64 bits keeps the low 64 bits of the 33x33 product exact.
  always_comb begin
    mul_a = {{32{((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[31]}}, a_q};
    mul_b = {{32{(op_q == OP_MULH) & b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
  end

  always_comb begin
    div_signed = ~op_q[0];
    is_rem     = op_q[1];
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    b_zero     = (b_q == 32'd0);
    sgn_ovf    = div_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    a_abs      = a_neg ? (32'd0 - a_q) : a_q;
    b_abs      = b_neg ? (32'd0 - b_q) : b_q;
  end

  // One restoring step: the shifted partial remainder can reach 33 bits.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    trial_ok  = (shifted >= {1'b0, div_q});
    rem_next  = trial_ok ? (shifted[31:0] - div_q) : shifted[31:0];
    quo_fixed = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    rem_fixed = neg_rem_q ? (32'd0 - rem_q) : rem_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      idx_q      <= '0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      div_q      <= 32'd0;
      cnt_q      <= 5'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      res_q      <= 32'd0;
      ready_q    <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_idx_q   <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.mdu_valid) begin
              op_q    <= bus.operation;
              a_q     <= bus.operand_a;
              b_q     <= bus.operand_b;
              idx_q   <= bus.idx_in;
              ready_q <= 1'b0;
              state_q <= bus.operation[2] ? DIV_PREP : MUL;
            end
          end
          MUL: begin
            res_q   <= (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
            state_q <= DONE;
          end
          DIV_PREP: begin
            // Quotient keeps its sign only for a real divisor, so x/0 stays all-ones.
            neg_quo_q <= (a_neg ^ b_neg) & ~b_zero;
            neg_rem_q <= a_neg;
            quo_q     <= a_abs;
            div_q     <= b_abs;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd31;
            if (FastDivSpecial && b_zero) begin
              res_q   <= is_rem ? a_q : 32'hFFFF_FFFF;
              state_q <= DONE;
            end else if (FastDivSpecial && sgn_ovf) begin
              res_q   <= is_rem ? 32'd0 : 32'h8000_0000;
              state_q <= DONE;
            end else begin
              state_q <= DIV_ITER;
            end
          end
          DIV_ITER: begin
            rem_q <= rem_next;
            quo_q <= {quo_q[30:0], trial_ok};
            if (cnt_q == 5'd0) begin
              state_q <= DIV_FIX;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          DIV_FIX: begin
            res_q   <= is_rem ? rem_fixed : quo_fixed;
            state_q <= DONE;
          end
          DONE: begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= res_q;
            wb_idx_q   <= idx_q;
            ready_q    <= 1'b1;
            state_q    <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.mdu_ready = ready_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_idx    = wb_idx_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - self-checking bench for mdu_unit, fast and iterative special-case builds
module tb_mdu_unit;
  localparam int IW = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;
  always #5 clock = ~clock;

  mdu_unit_if #(.IdxWidth(IW)) bus_f ();
  mdu_unit_if #(.IdxWidth(IW)) bus_s ();

  mdu_unit #(.IdxWidth(IW), .FastDivSpecial(1'b1)) u_fast (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus_f));
  mdu_unit #(.IdxWidth(IW), .FastDivSpecial(1'b0)) u_slow (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus_s));

  typedef struct {
    string         name;
    logic [31:0]   data;
    logic [IW-1:0] idx;
    int            acc;
    int            lat;
  } exp_t;

  typedef struct {
    string         name;
    int            sel;
    logic [2:0]    op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [IW-1:0] idx;
    logic [31:0]   exp;
    int            lat;
  } vec_t;

  exp_t q_f[$];
  exp_t q_s[$];
  vec_t vecs[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus_f.mdu_ready : bus_s.mdu_ready;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? q_f.size() : q_s.size();
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    r   = 32'd0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : (a / b);
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: r = (b == 0) ? a : (a % b);
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input int sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (sel == 0 && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 35;
  endfunction

  task automatic check_wb(input int sel, input logic [31:0] d, input logic [IW-1:0] ix);
    exp_t e;
    n_vec++;
    if (qsize(sel) == 0) begin
      n_bad++;
      $display("FAIL unexpected_wb dut%0d: got pulse data %h idx %0d, required no pulse", sel, d, ix);
      return;
    end
    e = (sel == 0) ? q_f.pop_front() : q_s.pop_front();
    if (d !== e.data || ix !== e.idx || (cyc - e.acc) != e.lat) begin
      n_bad++;
      $display("FAIL %s dut%0d: got data %h idx %0d lat %0d, required data %h idx %0d lat %0d",
               e.name, sel, d, ix, cyc - e.acc, e.data, e.idx, e.lat);
    end
  endtask

  always @(negedge clock) begin
    if (bus_f.wb_valid === 1'b1) check_wb(0, bus_f.wb_data, bus_f.wb_idx);
    if (bus_s.wb_valid === 1'b1) check_wb(1, bus_s.wb_data, bus_s.wb_idx);
  end

  task automatic drive(input int sel, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [IW-1:0] idx);
    if (sel == 0) begin
      bus_f.mdu_valid = v; bus_f.operation = op; bus_f.operand_a = a; bus_f.operand_b = b; bus_f.idx_in = idx;
    end else begin
      bus_s.mdu_valid = v; bus_s.operation = op; bus_s.operand_a = a; bus_s.operand_b = b; bus_s.idx_in = idx;
    end
  endtask

  task automatic accept_only(input int sel, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [IW-1:0] idx, output int acc);
    int w;
    w = 0;
    while (rdy(sel) !== 1'b1 && w < 100) begin
      @(negedge clock); #1; w++;
    end
    if (w >= 100) begin
      n_vec++; n_bad++;
      $display("FAIL ready_timeout dut%0d: got mdu_ready %b, required 1", sel, rdy(sel));
    end
    drive(sel, 1'b1, op, a, b, idx);
    @(negedge clock); #1;
    drive(sel, 1'b0, op, a, b, idx);
    acc = cyc;
  endtask

  task automatic run_op(input vec_t v);
    int   acc;
    int   w;
    bit   rdy_bad;
    exp_t e;
    accept_only(v.sel, v.op, v.a, v.b, v.idx, acc);
    e = '{v.name, v.exp, v.idx, acc, v.lat};
    if (v.sel == 0) q_f.push_back(e); else q_s.push_back(e);
    rdy_bad = (rdy(v.sel) !== 1'b0);
    w = 0;
    while (qsize(v.sel) != 0 && w < 60) begin
      @(negedge clock); #1; w++;
      if (qsize(v.sel) != 0 && rdy(v.sel) !== 1'b0) rdy_bad = 1'b1;
    end
    n_vec++;
    if (qsize(v.sel) != 0) begin
      n_bad++;
      $display("FAIL %s_no_wb dut%0d: got no pulse in %0d cycles, required data %h", v.name, v.sel, w, v.exp);
      if (v.sel == 0) q_f.delete(); else q_s.delete();
    end
    n_vec++;
    if (rdy_bad) begin
      n_bad++;
      $display("FAIL %s_ready_busy dut%0d: got mdu_ready 1 while busy, required 0", v.name, v.sel);
    end
  endtask

  task automatic check_idle(input string name, input logic [36:0] got, input logic [36:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got {valid,ready,data,idx} %h, required %h", name, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2ms, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    vec_t        v;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, '0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0, '0);
    repeat (3) @(negedge clock);
    #1;
    check_idle("reset_fast", {bus_f.wb_valid, bus_f.mdu_ready, bus_f.wb_data, bus_f.wb_idx}, {1'b0, 1'b1, 32'd0, 3'd0});
    check_idle("reset_slow", {bus_s.wb_valid, bus_s.mdu_ready, bus_s.wb_data, bus_s.wb_idx}, {1'b0, 1'b1, 32'd0, 3'd0});
    reset_n = 1'b1;
    @(negedge clock); #1;

    vecs.push_back('{"mul_lo",      0, 3'd0, 32'h0001_0000, 32'h0001_0000, 3'd5, 32'h0000_0000, 2});
    vecs.push_back('{"mulhu_small", 0, 3'd3, 32'h0001_0000, 32'h0001_0000, 3'd5, 32'h0000_0001, 2});
    vecs.push_back('{"mulh_m1",     0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0000, 2});
    vecs.push_back('{"mulhsu_m1",   0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'hFFFF_FFFF, 2});
    vecs.push_back('{"mulhu_max",   0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFE, 2});
    vecs.push_back('{"div_neg",     0, 3'd4, 32'hFFFF_FFF9, 32'd2,         3'd4, 32'hFFFF_FFFD, 35});
    vecs.push_back('{"rem_neg",     0, 3'd6, 32'hFFFF_FFF9, 32'd2,         3'd7, 32'hFFFF_FFFF, 35});
    vecs.push_back('{"divu_100_7",  0, 3'd5, 32'd100,       32'd7,         3'd0, 32'd14,        35});
    vecs.push_back('{"remu_100_7",  0, 3'd7, 32'd100,       32'd7,         3'd1, 32'd2,         35});
    for (int s = 0; s < 2; s++) begin
      vecs.push_back('{"divu_by0",  s, 3'd5, 32'h1234_5678, 32'd0,         3'd2, 32'hFFFF_FFFF, s == 0 ? 2 : 35});
      vecs.push_back('{"rem_by0",   s, 3'd6, 32'h1234_5678, 32'd0,         3'd3, 32'h1234_5678, s == 0 ? 2 : 35});
      vecs.push_back('{"div_ovf",   s, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h8000_0000, s == 0 ? 2 : 35});
      vecs.push_back('{"rem_ovf",   s, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000, s == 0 ? 2 : 35});
      vecs.push_back('{"divneg_by0", s, 3'd4, 32'hFFFF_FFF9, 32'd0,        3'd6, 32'hFFFF_FFFF, s == 0 ? 2 : 35});
      vecs.push_back('{"remneg_by0", s, 3'd6, 32'hFFFF_FFF9, 32'd0,        3'd7, 32'hFFFF_FFF9, s == 0 ? 2 : 35});
    end
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'd0 : $urandom;
      if (i == 5) begin rop = 3'd4; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (i == 7) begin rop = 3'd5; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      vecs.push_back('{"rand", i % 2, rop, ra, rb, 3'(i), ref_mdu(rop, ra, rb), ref_lat(i % 2, rop, ra, rb)});
    end

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // Flush during the tenth divide iteration: no pulse, then a fresh multiply.
    accept_only(0, 3'd4, 32'd1000, 32'd3, 3'd2, acc);
    while (cyc < acc + 10) begin @(negedge clock); #1; end
    flush = 1'b1;
    @(negedge clock); #1;
    flush = 1'b0;
    check_idle("flush_idle", {bus_f.wb_valid, bus_f.mdu_ready, 35'd0}, {1'b0, 1'b1, 35'd0});
    repeat (40) @(negedge clock);
    #1;
    v = '{"mul_after_flush", 0, 3'd0, 32'd3, 32'd4, 3'd6, 32'd12, 2};
    run_op(v);

    // Reset mid-divide discards the op and clears the writeback port.
    accept_only(0, 3'd5, 32'hDEAD_BEEF, 32'd9, 3'd3, acc);
    while (cyc < acc + 15) begin @(negedge clock); #1; end
    reset_n = 1'b0;
    @(negedge clock); #1;
    reset_n = 1'b1;
    check_idle("reset_mid_div", {bus_f.wb_valid, bus_f.mdu_ready, bus_f.wb_data, bus_f.wb_idx}, {1'b0, 1'b1, 32'd0, 3'd0});
    repeat (40) @(negedge clock);
    #1;
    v = '{"mul_after_reset", 0, 3'd1, 32'hFFFF_FFFE, 32'd3, 3'd7, 32'hFFFF_FFFF, 2};
    run_op(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
